// File: rtl/mul16_share_arb.sv
// ---------------------------------------------------------------------------
// mul16_share_arb
//
// Shares one pipelined 16x16 multiplier among N_REQ requesters. A
// combinational round-robin arbiter grants one requester per cycle. The
// granted operands are registered onto mul_a/mul_b. A tag pipeline, matched
// to the multiplier latency, carries {valid, id} for each operation, so each
// product can be returned on one tagged response bus.
//
// Parameters
//   N_REQ    number of requesters (2..8)
//   MUL_LAT  cycles from operands on mul_a/mul_b to product on mul_result
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   req_valid[i]     requester i has an operation pending
//   req_a, req_b     flattened operands; requester i uses [16i+15:16i]
//   req_ready        one-hot grant (zero while hold or reset is asserted)
//   hold             stop accepting; in-flight operations still complete
//   mul_a, mul_b     registered operands to the shared multiplier
//   mul_result       product from the shared multiplier
//   rsp_valid        one-cycle strobe per completed operation
//   rsp_id, rsp_data requester index and product of that operation
//   idle             nothing in flight and no response pending
//
// Optional feature, enabled by defining MUL16_ARB_PERF_EN:
//   perf_issue_cnt   handshakes accepted (wraps modulo 2^32)
//   perf_stall_cnt   cycles with a pending request but no handshake
// ---------------------------------------------------------------------------
module mul16_share_arb #(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*16-1:0]      req_a,
    input  logic [N_REQ*16-1:0]      req_b,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     hold,
    output logic [15:0]              mul_a,
    output logic [15:0]              mul_b,
    input  logic [31:0]              mul_result,
    output logic                     rsp_valid,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [31:0]              rsp_data,
`ifdef MUL16_ARB_PERF_EN
    output logic                     idle,
    output logic [31:0]              perf_issue_cnt,
    output logic [31:0]              perf_stall_cnt
`else
    output logic                     idle
`endif
);

    localparam int ID_W = $clog2(N_REQ);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [ID_W-1:0] last_grant;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] cand;
    logic            found;
    logic            hs;
    logic            any_tag;

    logic [15:0] op_a [N_REQ];
    logic [15:0] op_b [N_REQ];

    // The issue tag sits alongside mul_a/mul_b. The MUL_LAT stages behind it
    // put the last stage in the same cycle as the matching mul_result.
    tag_t issue_tag;
    tag_t tag_pipe [MUL_LAT];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            op_a[i] = req_a[16*i +: 16];
            op_b[i] = req_b[16*i +: 16];
        end
    end

    // Round-robin search that starts just after the last granted requester.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path through the block leaves a value unassigned (no latch).
        grant    = '0;
        grant_id = '0;
        cand     = '0;
        found    = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((int'(last_grant) + 1 + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                grant[cand] = 1'b1;
                grant_id    = cand;
                found       = 1'b1;
            end
        end
    end

    assign req_ready = (hold || !rst_n) ? '0 : grant;
    assign hs        = |(req_valid & req_ready);

    always_comb begin
        any_tag = issue_tag.vld;
        for (int k = 0; k < MUL_LAT; k++) begin
            any_tag = any_tag | tag_pipe[k].vld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a      <= '0;
            mul_b      <= '0;
            last_grant <= ID_W'(N_REQ - 1);
            issue_tag  <= '0;
            // NOTE: the tag pipe is a short shift register, so it is reset
            // like any other state. Clearing its valids is what discards
            // in-flight products, because the multiplier itself has no reset.
            for (int k = 0; k < MUL_LAT; k++) begin
                tag_pipe[k] <= '0;
            end
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            idle       <= 1'b1;
        end else begin
            // NOTE: state is updated with non-blocking assignments, so every
            // register here samples values from before the edge.
            if (hs) begin
                mul_a      <= op_a[grant_id];
                mul_b      <= op_b[grant_id];
                last_grant <= grant_id;
            end
            issue_tag   <= '{vld: hs, id: grant_id};
            tag_pipe[0] <= issue_tag;
            for (int k = 1; k < MUL_LAT; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
            rsp_valid <= tag_pipe[MUL_LAT-1].vld;
            if (tag_pipe[MUL_LAT-1].vld) begin
                rsp_id   <= tag_pipe[MUL_LAT-1].id;
                rsp_data <= mul_result;
            end
            idle <= !(hs || any_tag || rsp_valid);
        end
    end

`ifdef MUL16_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (hs) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
            if (|req_valid && !hs) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mul16_share_arb.sv
// ---------------------------------------------------------------------------
// tb_mul16_share_arb
//
// Bench for mul16_share_arb at default parameters. It contains a behavioural
// model of the shared multiplier (a plain product delay line) and a reference
// model of the scheduler, which keeps a queue of expected responses, each
// with the cycle it is due. Every cycle a compare process checks all outputs
// against that model. The stimulus process walks through the scenarios and
// adds a few hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_mul16_share_arb;

    localparam int N_REQ   = 4;
    localparam int MUL_LAT = 6;
    localparam int ID_W    = 2;
    localparam int RSP_LAT = MUL_LAT + 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  hold = 1'b0;
    logic [N_REQ-1:0]      req_valid = '0;
    logic [N_REQ*16-1:0]   req_a = '0;
    logic [N_REQ*16-1:0]   req_b = '0;
    logic [N_REQ-1:0]      req_ready;
    logic [15:0]           mul_a;
    logic [15:0]           mul_b;
    logic [31:0]           mul_result;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_data;
    logic                  idle;
`ifdef MUL16_ARB_PERF_EN
    logic [31:0]           perf_issue_cnt;
    logic [31:0]           perf_stall_cnt;
`endif

    mul16_share_arb #(.N_REQ(N_REQ), .MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .hold       (hold),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
`ifdef MUL16_ARB_PERF_EN
        .idle           (idle),
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`else
        .idle       (idle)
`endif
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared multiplier: the product of the operands appears MUL_LAT cycles later.
    logic [31:0] mpipe [MUL_LAT];
    always @(posedge clk) begin
        mpipe[0] <= 32'(mul_a) * 32'(mul_b);
        for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_result = mpipe[MUL_LAT-1];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          id;
        logic [31:0] data;
        longint      due;
    } exp_t;

    exp_t        exp_q[$];
    int          m_last     = N_REQ - 1;
    longint      m_last_hs  = -1000;
    logic [15:0] m_a        = '0;
    logic [15:0] m_b        = '0;
    int          m_rsp_id   = 0;
    logic [31:0] m_rsp_data = '0;

    function automatic int rr_pick(input int last, input logic [N_REQ-1:0] v);
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (last + 1 + k) % N_REQ;
            if (v[ID_W'(idx)]) return idx;
        end
        return -1;
    endfunction

    initial begin : compare
        int               pick;
        logic [N_REQ-1:0] exp_ready;
        logic             exp_rv;
        exp_t             e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                m_last     = N_REQ - 1;
                m_last_hs  = -1000;
                m_a        = '0;
                m_b        = '0;
                m_rsp_id   = 0;
                m_rsp_data = '0;
            end
            pick      = (hold || !rst_n) ? -1 : rr_pick(m_last, req_valid);
            exp_ready = (pick < 0) ? '0 : (N_REQ'(1) << pick);
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            exp_rv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            if (exp_rv) begin
                e          = exp_q.pop_front();
                m_rsp_id   = e.id;
                m_rsp_data = e.data;
            end
            check("rsp_id", 64'(rsp_id), 64'(m_rsp_id));
            check("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
            // idle rises once a full latency plus two registered cycles have passed since the last handshake
            check("idle", 64'(idle), 64'((cyc - m_last_hs) >= MUL_LAT + 4));
            check("mul_a", 64'(mul_a), 64'(m_a));
            check("mul_b", 64'(mul_b), 64'(m_b));
            if (pick >= 0) begin
                m_a = req_a[16*pick +: 16];
                m_b = req_b[16*pick +: 16];
                e.id   = pick;
                e.data = 32'(m_a) * 32'(m_b);
                e.due  = cyc + RSP_LAT;
                exp_q.push_back(e);
                m_last    = pick;
                m_last_hs = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (idle) break;
        end
        check("wait_idle", 64'(idle), 64'd1);
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < N_REQ; i++)
            set_op(i, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin : stim
        int order [8];
        int n_rsp;
        order = '{3, 0, 1, 2, 3, 0, 1, 2};

        // Reset: grants forced off even with every requester valid.
        req_valid = '1;
        tick();
        tick();
        @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_idle", 64'(idle), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        req_valid = '0;

        // Single request from requester 2.
        tick();
        set_op(2, 16'hFFFF, 16'hFFFF);
        req_valid = 4'b0100;
        @(negedge clk);
        check("single_grant", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        repeat (6) tick();
        @(negedge clk);
        check("single_early", 64'(rsp_valid), 64'd0);
        tick();
        @(negedge clk);
        check("single_rsp_valid", 64'(rsp_valid), 64'd1);
        check("single_rsp_id", 64'(rsp_id), 64'd2);
        check("single_rsp_data", 64'(rsp_data), 64'hFFFE0001);

        // Full contention: last grant was 2, so rotation starts at 3.
        wait_idle();
        tick();
        for (int i = 0; i < N_REQ; i++) set_op(i, 16'(i + 1), 16'h0100);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_grant", 64'(req_ready), 64'(4'(1) << order[k]));
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        check("rr_rsp0_id", 64'(rsp_id), 64'd3);
        check("rr_rsp0_data", 64'(rsp_data), 64'h400);
        tick();
        @(negedge clk);
        check("rr_rsp1_id", 64'(rsp_id), 64'd0);
        check("rr_rsp1_data", 64'(rsp_data), 64'h100);

        // Throughput: requester 1 alone streams 20 random pairs.
        wait_idle();
        tick();
        n_rsp = 0;
        for (int i = 0; i < 20; i++) begin
            set_op(1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
            req_valid = 4'b0010;
            @(negedge clk);
            n_rsp += int'(rsp_valid);
            tick();
        end
        req_valid = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_rsp += int'(rsp_valid);
            tick();
        end
        check("stream_count", 64'(n_rsp), 64'd20);

        // Hold/drain: three issues (2,3,0), then hold with everyone valid.
        wait_idle();
        tick();
        randomize_ops();
        req_valid = '1;
        @(negedge clk);
        check("hold_pre0", 64'(req_ready), 64'h4);
        tick();
        @(negedge clk);
        check("hold_pre1", 64'(req_ready), 64'h8);
        tick();
        @(negedge clk);
        check("hold_pre2", 64'(req_ready), 64'h1);
        tick();
        hold = 1'b1;
        @(negedge clk);
        check("hold_ready", 64'(req_ready), 64'd0);
        n_rsp = 0;
        for (int k = 1; k <= MUL_LAT + 3; k++) begin
            tick();
            @(negedge clk);
            n_rsp += int'(rsp_valid);
            if (idle) break;
        end
        check("hold_idle", 64'(idle), 64'd1);
        check("hold_rsp_count", 64'(n_rsp), 64'd3);
        tick();
        hold = 1'b0;
        @(negedge clk);
        check("hold_resume", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;

        // Reset mid-flight: four issues, then reset three cycles later.
        wait_idle();
        tick();
        randomize_ops();
        req_valid = '1;
        repeat (4) tick();
        req_valid = '0;
        repeat (2) tick();
        rst_n = 1'b0;
        req_valid = '1;
        @(negedge clk);
        check("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mrst_rsp_id", 64'(rsp_id), 64'd0);
        check("mrst_rsp_data", 64'(rsp_data), 64'd0);
        check("mrst_mul_a", 64'(mul_a), 64'd0);
        check("mrst_mul_b", 64'(mul_b), 64'd0);
        check("mrst_idle", 64'(idle), 64'd1);
        check("mrst_req_ready", 64'(req_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        req_valid = '0;
        n_rsp = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            n_rsp += int'(rsp_valid);
            tick();
        end
        check("mrst_no_rsp", 64'(n_rsp), 64'd0);

`ifdef MUL16_ARB_PERF_EN
        // Perf counters: ten contended cycles without hold, then five held.
        randomize_ops();
        req_valid = 4'b0011;
        repeat (10) tick();
        hold = 1'b1;
        @(negedge clk);
        check("perf_issue", 64'(perf_issue_cnt), 64'd10);
        check("perf_stall0", 64'(perf_stall_cnt), 64'd0);
        repeat (5) tick();
        hold = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("perf_stall5", 64'(perf_stall_cnt), 64'd5);
`endif

        wait_idle();
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
